// File: rtl/param_sdp_ram.sv
// Parametrised simple-dual-port RAM: byte-enabled writes, registered write-first
// reads, address-range checking and a zeroing sweep after reset or on request.
module param_sdp_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              addr_err
);

  localparam int unsigned AW1 = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                wr_ok_c;
  logic                rd_ok_c;
  logic                wr_acc_c;
  logic                rd_acc_c;
  logic [DATA_W-1:0]   rd_word_c;

  // Range checks and port acceptance; both ports are frozen during a sweep.
  always_comb begin
    wr_ok_c  = {1'b0, wr_addr} < AW1'(DEPTH);
    rd_ok_c  = {1'b0, rd_addr} < AW1'(DEPTH);
    wr_acc_c = !busy && wr_en && wr_ok_c;
    rd_acc_c = !busy && rd_en;
  end

  // Write-first bypass: enabled bytes of a same-address write replace stored bytes.
  always_comb begin
    rd_word_c = mem[rd_addr];
    for (int i = 0; i < BE_W; i++) begin
      if (wr_acc_c && (wr_addr == rd_addr) && wr_be[i]) begin
        rd_word_c[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  // Clear-sweep FSM; a clr request in either state restarts at word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr) begin
            cnt <= '0;
          end else if (cnt == LAST) begin
            state <= ST_READY;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        ST_READY: begin
          if (clr) begin
            state <= ST_CLEAR;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_CLEAR;
          busy  <= 1'b1;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Storage array; not reset, zeroed by the sweep instead.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[cnt] <= '0;
    end else if (wr_acc_c) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Registered read port and range-error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= rd_acc_c;
      addr_err <= !busy && ((wr_en && !wr_ok_c) || (rd_en && !rd_ok_c));
      if (rd_acc_c) begin
        rd_data <= rd_ok_c ? rd_word_c : '0;
      end
    end
  end

endmodule

// File: doc/param_sdp_ram.md
Name: param_sdp_ram

Overview:
- Parametrised simple-dual-port RAM; next generation of the team's 16x8 single-port RAM.
- One write port and one independent read port, both in one clock domain.
- Adds: configurable width/depth, per-byte write enables, registered synchronous read with valid flag, write-first bypass, address-range checking, and a hardware clear engine that zeroes the array after reset or on request.
- Serves as the general scratchpad/buffer storage for datapath blocks.

Parameters:
DATA_W, 16, word width in bits; must be a multiple of 8, minimum 8
ADDR_W, 4, address width in bits
DEPTH, 16, number of words; 1 <= DEPTH <= 2**ADDR_W
BE_W, DATA_W/8, number of byte enables (derived; not overridden)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  one-cycle request to re-zero the whole array
busy  out  1  clear sweep in progress; both ports are ignored while high
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write address
wr_be  in  BE_W  byte enables; bit i covers wr_data[8i+7:8i]
wr_data  in  DATA_W  write data
rd_en  in  1  read strobe
rd_addr  in  ADDR_W  read address
rd_data  out  DATA_W  registered read data
rd_valid  out  1  one-cycle pulse: rd_data is updated this cycle
addr_err  out  1  one-cycle pulse: previous-cycle access was out of range

Behaviour:
- Reset (rst_n low, asynchronous):
  - busy=1, rd_valid=0, rd_data=0, addr_err=0.
  - Sweep counter=0; FSM=CLEAR.
  - Array contents are not reset directly.
- FSM, two states:
  - CLEAR: each cycle writes 0 to word[cnt], then cnt++. When cnt==DEPTH-1 is written, go to READY on the next edge. busy=1 throughout.
  - READY: busy=0. clr=1 -> CLEAR with cnt=0; busy rises the next cycle.
- Sweep timing: takes exactly DEPTH cycles after the first rising edge following rst_n release. busy falls after edge DEPTH.
- clr in CLEAR restarts the sweep at cnt=0. rst_n low mid-sweep aborts it; the sweep restarts from 0 after release.
- While busy=1:
  - wr_en and rd_en are ignored.
  - rd_valid=0, addr_err=0, rd_data holds its value.
- Write (busy=0, wr_en=1, wr_addr<DEPTH): on the edge, for each i with wr_be[i]=1, update byte i of word[wr_addr]. Bytes with wr_be[i]=0 are unchanged. wr_be=0 is a legal no-op.
- Read (busy=0, rd_en=1, rd_addr<DEPTH): latency 1. On the edge:
  - rd_data <= word[rd_addr];
  - rd_valid=1 for that one cycle.
  - rd_data holds its value until the next accepted read.
- Read-during-write to the same address in the same cycle is write-first. rd_data = stored word with the enabled bytes replaced by wr_data.
- Out of range (addr >= DEPTH; only possible when DEPTH < 2**ADDR_W):
  - A write is dropped and the array is unchanged.
  - A read sets rd_data=0 and rd_valid=1.
  - Either case pulses addr_err=1 on the next cycle; a write and a read both out of range give a single pulse.
- Simultaneous write and read to different addresses are independent and complete in the same cycle.
- No data corruption from back-to-back accesses; one read and one write may be accepted every cycle.

Test Plan:
- Reset release, defaults (DATA_W=16, DEPTH=16): busy=1 for exactly 16 cycles, then 0. Reading all 16 addresses returns 0x0000 with rd_valid one cycle after each rd_en.
- Byte enables: write 0xA5C3 with be=11 to addr 3, then 0x00FF with be=01 to addr 3, then read addr 3 -> rd_data=0xA5FF. be=00 writes leave the word unchanged.
- Write-first bypass: word 7 holds 0x1234. In the same cycle write 0xBEEF with be=10 and read addr 7 -> next cycle rd_data=0xBE34, rd_valid=1.
- Clear engine: fill all words with 0xFFFF, pulse clr. busy=1 for 16 cycles; wr_en/rd_en during busy have no effect (rd_valid stays 0). Afterwards every read returns 0x0000. A second clr at sweep cycle 5 extends busy to 5+16 cycles.
- Out of range (DEPTH=12, ADDR_W=4): write 0x5555 to addr 13 -> addr_err pulse, array unchanged. Read addr 14 -> rd_data=0x0000, rd_valid=1, addr_err=1.
- Reset mid-sweep: assert rst_n low at sweep cycle 8. Outputs return to reset values asynchronously. After release, busy lasts a full 16 cycles and all words read 0x0000.
